// File: rtl/display_arbiter.sv
// Shares the 4-digit 7-segment driver among three sources (live time, alarm editor,
// alarm flash) with fixed priority, a minimum hold time and per-digit blinking.
module display_arbiter #(
    parameter int TICK_DIV    = 50000,
    parameter int BLINK_TICKS = 250,
    parameter int MIN_HOLD    = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [27:0] seg_in0,
    input  logic [27:0] seg_in1,
    input  logic [27:0] seg_in2,
    input  logic [11:0] blink_mask,
    output logic [2:0]  gnt,
    output logic [6:0]  num0,
    output logic [6:0]  num1,
    output logic [6:0]  num2,
    output logic [6:0]  num3,
    output logic        state_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [6:0]    BLANK      = 7'h7F;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [3:0][6:0] num_q, num_d;
    logic            tick;
    logic            grant_change;
    logic [2:0]      pend_hi;
    logic [27:0]     owner_seg;
    logic [3:0]      owner_mask;

    // FSM state register, grant and display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            num_q   <= {4{BLANK}};
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            num_q   <= num_d;
        end
    end

    // FSM next state: one-hot grants compare numerically because higher index = higher priority
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        pend_hi = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    gnt_d   = pend_hi;
                end
            end
            OWN: begin
                if ((gnt_q & req) == 3'b000) begin
                    gnt_d   = pend_hi;
                    state_d = (|req) ? OWN : IDLE;
                end else if (hold_q == HOLD_MAX && pend_hi > gnt_q) begin
                    gnt_d = pend_hi;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // Outputs: owner digit mux with per-digit blanking during the blanked phase
    always_comb begin
        owner_seg  = 28'd0;
        owner_mask = 4'd0;
        if (gnt_q[2]) begin
            owner_seg  = seg_in2;
            owner_mask = blink_mask[11:8];
        end else if (gnt_q[1]) begin
            owner_seg  = seg_in1;
            owner_mask = blink_mask[7:4];
        end else if (gnt_q[0]) begin
            owner_seg  = seg_in0;
            owner_mask = blink_mask[3:0];
        end
        for (int k = 0; k < 4; k++) begin
            if (state_q == IDLE || (owner_mask[k] && phase_q)) begin
                num_d[k] = BLANK;
            end else begin
                num_d[k] = owner_seg[k*7 +: 7];
            end
        end
        gnt     = gnt_q;
        state_o = state_q;
        num0    = num_q[0];
        num1    = num_q[1];
        num2    = num_q[2];
        num3    = num_q[3];
    end

    // Tick, hold and blink counters; hold and blink restart on every grant change
    assign tick         = (tick_cnt_q == TICK_LAST);
    assign grant_change = (gnt_d != gnt_q);

    always_comb begin
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (grant_change) begin
            hold_d      = '0;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (tick) begin
            if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

endmodule
